// File: rtl/tx_scrambler.sv
// tx_scrambler
//   Self-synchronous 64b/66b transmit scrambler, polynomial 1 + x^39 + x^58.
//   The 64-bit payload is scrambled LSB first, all 64 steps in one cycle.
//   The 2-bit sync header passes through untouched. A single output register
//   stage with combinational ready gives back-to-back throughput. A saturating
//   counter tracks accepted blocks carrying an illegal header (2'b00 / 2'b11).
//
// Ports
//   tx_clk          clock, rising edge
//   tx_rst          asynchronous reset, active low
//   data_in         unscrambled block {header[1:0], payload[63:0]}
//   data_valid_in   data_in valid
//   data_ready_out  block can accept data_in this cycle
//   data_out        scrambled block (registered)
//   data_valid_out  data_out valid
//   data_ready_in   downstream accepts data_out this cycle
//   bypass          pass the payload unscrambled, sampled per accepted block
//   cnt_clear       synchronous clear of bad_hdr_cnt (wins over increment)
//   bad_hdr_cnt     saturating count of illegal headers

module tx_scrambler #(
    parameter int          DATA_WIDTH = 66,
    parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    input  logic                  data_ready_in,
    input  logic                  bypass,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  bad_hdr_cnt
);

    logic [57:0]           lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dv_q, dv_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [57:0]           lfsr_next;
    logic [63:0]           pay_scr;
    logic [1:0]            hdr;
    logic                  accept;
    logic                  consume;
    logic                  hdr_bad;

    assign hdr            = data_in[DATA_WIDTH-1:DATA_WIDTH-2];
    assign data_ready_out = !dv_q || data_ready_in;
    assign accept         = data_valid_in && data_ready_out;
    assign consume        = dv_q && data_ready_in;
    assign hdr_bad        = (hdr == 2'b00) || (hdr == 2'b11);

    // Unrolled bit-serial scrambler: each scrambled bit is fed back into
    // the state before the next payload bit is processed.
    always_comb begin
        logic s_bit;
        lfsr_next = lfsr_q;
        pay_scr   = '0;
        s_bit     = 1'b0;
        for (int i = 0; i < 64; i++) begin
            s_bit      = data_in[i] ^ lfsr_next[38] ^ lfsr_next[57];
            pay_scr[i] = s_bit;
            lfsr_next  = {lfsr_next[56:0], s_bit};
        end
    end

    always_comb begin
        dout_d = dout_q;
        dv_d   = dv_q;
        lfsr_d = lfsr_q;
        if (accept) begin
            dout_d[DATA_WIDTH-1:DATA_WIDTH-2] = hdr;
            dout_d[63:0] = bypass ? data_in[63:0] : pay_scr;
            dv_d         = 1'b1;
            // A bypassed block leaves the scrambler state untouched so the
            // descrambler stays aligned with the scrambled stream.
            if (!bypass) begin
                lfsr_d = lfsr_next;
            end
        end else if (consume) begin
            dv_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (accept && hdr_bad && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            lfsr_q <= SEED;
            dout_q <= '0;
            dv_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_out       = dout_q;
    assign data_valid_out = dv_q;
    assign bad_hdr_cnt    = cnt_q;

endmodule

// File: tb/tb_tx_scrambler.sv
module tb_tx_scrambler;

    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic [65:0] data_in;
    logic        data_valid_in;
    logic        data_ready_out;
    logic [65:0] data_out;
    logic        data_valid_out;
    logic        data_ready_in;
    logic        bypass;
    logic        cnt_clear;
    logic [3:0]  bad_hdr_cnt;

    tx_scrambler #(.DATA_WIDTH(66), .SEED(SEED), .CNT_WIDTH(4)) dut (
        .tx_clk        (tx_clk),
        .tx_rst        (tx_rst),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .data_ready_out(data_ready_out),
        .data_out      (data_out),
        .data_valid_out(data_valid_out),
        .data_ready_in (data_ready_in),
        .bypass        (bypass),
        .cnt_clear     (cnt_clear),
        .bad_hdr_cnt   (bad_hdr_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [65:0] blk;
        logic        byp;
    } sb_t;

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] pay;
        logic        byp;
        logic        clr;
        logic [3:0]  exp_cnt;
    } vec_t;

    sb_t         sbq[$];
    vec_t        tbl[7];
    int          total = 0;
    int          bad   = 0;
    int          n_push = 0;
    logic [57:0] ds;
    logic [3:0]  exp_cnt;
    logic [65:0] held;

    localparam logic [65:0] KNOWN_OUT = {2'b01, 64'h03FF_FF80_0000_0000};

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bit-serial descrambler: the received (scrambled) bit enters the state.
    task automatic descr(input logic [63:0] p, output logic [63:0] r);
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = p[i] ^ ds[38] ^ ds[57];
            ds   = {ds[56:0], p[i]};
        end
    endtask

    // Called at a falling edge with inputs already driven; ends at the next falling edge.
    task automatic step();
        sb_t         e;
        logic [63:0] rec;
        logic        acc;
        logic        cons;
        #1;
        chk("ready_rule", {65'd0, data_ready_out}, {65'd0, (!data_valid_out || data_ready_in)});
        chk("cnt_model", {62'd0, bad_hdr_cnt}, {62'd0, exp_cnt});
        acc  = data_valid_in && data_ready_out;
        cons = data_valid_out && data_ready_in;
        if (cons) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=%h required=none", data_out);
            end else begin
                e = sbq.pop_front();
                chk("hdr", {64'd0, data_out[65:64]}, {64'd0, e.blk[65:64]});
                if (e.byp) rec = data_out[63:0];
                else descr(data_out[63:0], rec);
                chk("payload", {2'b00, rec}, {2'b00, e.blk[63:0]});
            end
        end
        if (acc) begin
            sbq.push_back('{data_in, bypass});
            n_push++;
        end
        if (cnt_clear) exp_cnt = 4'd0;
        else if (acc && (data_in[65:64] == 2'b00 || data_in[65:64] == 2'b11) && exp_cnt != 4'hF)
            exp_cnt = exp_cnt + 4'd1;
        @(posedge tx_clk);
        @(negedge tx_clk);
    endtask

    // Asserts reset mid-cycle and checks outputs immediately, without a clock edge.
    task automatic do_reset();
        #2 tx_rst = 1'b0;
        #1;
        chk("rst_dout", data_out, 66'd0);
        chk("rst_dv", {65'd0, data_valid_out}, 66'd0);
        chk("rst_ready", {65'd0, data_ready_out}, 66'd1);
        chk("rst_cnt", {62'd0, bad_hdr_cnt}, 66'd0);
        sbq.delete();
        ds      = SEED;
        exp_cnt = 4'd0;
        @(negedge tx_clk);
        @(negedge tx_clk);
        tx_rst = 1'b1;
    endtask

    task automatic known_vector();
        data_in       = {2'b01, 64'h0};
        data_valid_in = 1'b1;
        data_ready_in = 1'b1;
        bypass        = 1'b0;
        cnt_clear     = 1'b0;
        step();
        chk("known_dv", {65'd0, data_valid_out}, 66'd1);
        chk("known_out", data_out, KNOWN_OUT);
        data_valid_in = 1'b0;
        step();
    endtask

    initial begin
        int start;
        int cyc;

        tbl[0] = '{2'b01, 64'hDEADBEEF_01234567, 1'b1, 1'b0, 4'd0};
        tbl[1] = '{2'b11, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 4'd1};
        tbl[2] = '{2'b11, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, 4'd2};
        tbl[3] = '{2'b00, 64'h5555_AAAA_5555_AAAA, 1'b1, 1'b0, 4'd3};
        tbl[4] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'd3};
        tbl[5] = '{2'b11, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 4'd0};
        tbl[6] = '{2'b00, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'd1};

        tx_rst        = 1'b1;
        data_in       = '0;
        data_valid_in = 1'b0;
        data_ready_in = 1'b0;
        bypass        = 1'b0;
        cnt_clear     = 1'b0;
        ds            = SEED;
        exp_cnt       = 4'd0;
        @(negedge tx_clk);
        do_reset();

        known_vector();

        // Table: one block per cycle, consume and accept together.
        data_ready_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in       = {tbl[i].hdr, tbl[i].pay};
            data_valid_in = 1'b1;
            bypass        = tbl[i].byp;
            cnt_clear     = tbl[i].clr;
            step();
            chk($sformatf("tbl_cnt_%0d", i), {62'd0, bad_hdr_cnt}, {62'd0, tbl[i].exp_cnt});
            if (tbl[i].byp)
                chk($sformatf("tbl_bypass_%0d", i), {2'b00, data_out[63:0]}, {2'b00, tbl[i].pay});
        end
        data_valid_in = 1'b0;
        bypass        = 1'b0;
        cnt_clear     = 1'b0;
        step();

        // Stall: downstream blocks for 5 cycles while a new block waits.
        data_in       = {2'b01, 64'hCAFE_F00D_1234_5678};
        data_valid_in = 1'b1;
        step();
        held          = data_out;
        data_ready_in = 1'b0;
        data_in       = {2'b10, 64'h0F0F_0F0F_F0F0_F0F0};
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold", data_out, held);
            chk("stall_dv", {65'd0, data_valid_out}, 66'd1);
            chk("stall_ready", {65'd0, data_ready_out}, 66'd0);
        end
        data_ready_in = 1'b1;
        step();
        data_valid_in = 1'b0;
        step();

        // Saturation: exp_cnt is 1 here; 14 bad headers reach 15, one more stays.
        data_valid_in = 1'b1;
        for (int i = 0; i < 14; i++) begin
            data_in = {2'b11, 32'($urandom()), 32'($urandom())};
            step();
        end
        chk("sat_15", {62'd0, bad_hdr_cnt}, 66'd15);
        data_in = {2'b00, 64'h1};
        step();
        chk("sat_hold", {62'd0, bad_hdr_cnt}, 66'd15);
        cnt_clear = 1'b1;
        data_in   = {2'b11, 64'h2};
        step();
        chk("clear_prio", {62'd0, bad_hdr_cnt}, 66'd0);
        cnt_clear     = 1'b0;
        data_valid_in = 1'b0;
        step();

        // Reset with a held block: it is dropped and scrambling restarts from SEED.
        data_in       = {2'b01, 64'hABCD_0000_1111_2222};
        data_valid_in = 1'b1;
        data_ready_in = 1'b0;
        step();
        data_valid_in = 1'b0;
        do_reset();
        chk("post_rst_dv", {65'd0, data_valid_out}, 66'd0);
        known_vector();

        // Random round trip through the descrambler model.
        start = n_push;
        cyc   = 0;
        while ((n_push - start) < 1000 && cyc < 20000) begin
            data_valid_in = ($urandom_range(0, 3) != 0);
            data_ready_in = ($urandom_range(0, 3) != 0);
            data_in       = {2'($urandom_range(0, 3)), 32'($urandom()), 32'($urandom())};
            bypass        = ($urandom_range(0, 7) == 0);
            cnt_clear     = ($urandom_range(0, 31) == 0);
            step();
            cyc++;
        end
        if ((n_push - start) < 1000) begin
            total++;
            bad++;
            $display("FAIL rand_timeout actual=%0d required=1000", n_push - start);
        end
        data_valid_in = 1'b0;
        data_ready_in = 1'b1;
        bypass        = 1'b0;
        cnt_clear     = 1'b0;
        cyc = 0;
        while (sbq.size() > 0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("sb_drained", 66'(sbq.size()), 66'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
